// File: rtl/hamming_pkg.sv
// Shared types and widths for the 12/8 Hamming path.
// Used by the receiver, encoder/decoder and transmit serializer.
package hamming_pkg;

  localparam int HC_W = 12;
  localparam int HD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hamming_frame_rx.sv
// Serial receive front-end: start bit, 12 codeword bits LSB first,
// stop bit; presents the codeword with a one-cycle strobe.
module hamming_frame_rx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            rx_serial,
  output logic [HC_W-1:0] hc_out,
  output logic            hc_valid,
  output logic            frame_err,
  output logic            busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] N_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] IDX_LAST = 4'(HC_W - 1);

  if ((CLKS_PER_BIT % 2 != 0) || (CLKS_PER_BIT < 4)) begin : g_bad_cfg
    $error("CLKS_PER_BIT must be even and >= 4");
  end

  logic rx_s;

  rx_state_e       state, state_d;
  logic [CW-1:0]   bit_cnt, bit_cnt_d;
  logic [3:0]      bit_idx, bit_idx_d;
  logic [HC_W-1:0] shreg, shreg_d;
  logic [HC_W-1:0] hc_out_d;
  logic            valid_d, err_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .arst(arst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt + 1'b1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    hc_out_d  = hc_out;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (bit_cnt == H_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == N_LAST) begin
          bit_cnt_d        = '0;
          shreg_d[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) state_d = STOP;
          else bit_idx_d = bit_idx + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start bit is seen.
        if (bit_cnt == N_LAST) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) begin
            hc_out_d = shreg;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hc_out    <= '0;
      hc_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      hc_out    <= hc_out_d;
      hc_valid  <= valid_d;
      frame_err <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
